// File: rtl/uart_tx.sv
// UART transmit serialiser: pops FIFO words and shifts out start/data/parity/stop bits.
// tx goes low the cycle after in_pop. Pops only when idle and enabled, at most once per frame.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    output logic                 g_clk_req,
    input  logic                 cfg_en,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_stop2,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_pop,
    output logic                 tx,
    output logic                 busy
);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] reload;

    assign div_eff   = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
    assign reload    = div_q - DIV_WIDTH'(1);
    assign in_pop    = (state_q == S_IDLE) & cfg_en & in_valid & ~g_reset;
    assign busy      = (state_q != S_IDLE);
    assign g_clk_req = busy | (cfg_en & in_valid);
    assign tx        = tx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        tx_d       = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (in_pop) begin
                    state_d   = S_START;
                    cnt_d     = div_eff - DIV_WIDTH'(1);
                    div_d     = div_eff;
                    shift_d   = in_data;
                    par_bit_d = (^in_data) ^ cfg_parity_odd;
                    par_en_d  = cfg_parity_en;
                    stop2_d   = cfg_stop2;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = reload;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = reload;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_d    = S_STOP;
                    cnt_d      = reload;
                    stop_idx_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        cnt_d      = reload;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next state so the line tracks state_q exactly.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single frames plus back-to-back, reset and enable sequences.
module tb_uart_tx;
    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        g_clk_req;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_div = 16'd1;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_pop;
    logic        tx;
    logic        busy;

    uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req),
        .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .in_valid(in_valid), .in_data(in_data), .in_pop(in_pop),
        .tx(tx), .busy(busy)
    );

    always #5 g_clk = ~g_clk;

    int passed = 0;
    int total  = 0;
    int pops   = 0;
    logic [7:0] fifo_q[$];
    logic cap_tx[0:255];
    logic cap_busy[0:255];

    // FIFO model: pop is seen mid-cycle, the head advances just after the clock edge.
    initial begin
        logic pend;
        forever begin
            @(negedge g_clk);
            pend = in_pop;
            if (pend) pops++;
            @(posedge g_clk);
            #1;
            if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
            in_valid = (fifo_q.size() != 0);
            in_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_pop(input string name);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge g_clk);
            if (in_pop) begin ok = 1; break; end
        end
        total++;
        if (ok) passed++;
        else $display("FAIL %s_pop_timeout: got no pop expected pop", name);
    endtask

    // Samples n cycles starting the cycle after the pop; optionally drops cfg_en mid-frame.
    task automatic capture(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(posedge g_clk);
            #2;
            if (i == drop_at) begin cfg_en = 1'b0; cfg_div = 16'd2; end
            @(negedge g_clk);
            cap_tx[i]   = tx;
            cap_busy[i] = busy;
        end
    endtask

    task automatic check_frame(input string name, input int base, input logic [11:0] bits,
                               input int nbits, input int bitlen);
        int len = 0;
        int mism = 0;
        while (base + len < 256 && cap_busy[base + len] && len < 200) len++;
        chk({name, "_len"}, len, nbits * bitlen);
        for (int c = 0; c < nbits * bitlen; c++)
            if (cap_tx[base + c] !== bits[c / bitlen]) mism++;
        chk({name, "_wave_mism"}, mism, 0);
        chk({name, "_idle_after"}, {cap_busy[base + nbits * bitlen], cap_tx[base + nbits * bitlen]}, 2'b01);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        par_en;
        logic        par_odd;
        logic        stop2;
        logic [11:0] bits;   // line bits in send order, bit 0 = start bit
        int          nbits;
        int          bitlen;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p0;
        // 0x55: 0,1,0,1,0,1,0,1,0,1
        vecs[0] = '{8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 4};
        // 0x07 even parity -> parity 1
        vecs[1] = '{8'h07, 16'd3, 1'b1, 1'b0, 1'b0, 12'h60E, 11, 3};
        // 0x07 odd parity -> parity 0
        vecs[2] = '{8'h07, 16'd3, 1'b1, 1'b1, 1'b0, 12'h40E, 11, 3};
        // div 0 acts as 1: 0 then nine 1s
        vecs[3] = '{8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 12'h3FE, 10, 1};
        // 0xA0 two stop bits
        vecs[4] = '{8'hA0, 16'd2, 1'b0, 1'b0, 1'b1, 12'h740, 11, 2};

        repeat (3) @(negedge g_clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pop", in_pop, 1'b0);
        @(posedge g_clk); #2;
        g_reset = 1'b0;
        cfg_en  = 1'b1;
        repeat (4) @(negedge g_clk);
        chk("idle_novalid_tx", tx, 1'b1);
        chk("idle_novalid_pop", in_pop, 1'b0);
        chk("idle_novalid_req", g_clk_req, 1'b0);

        for (int v = 0; v < 5; v++) begin
            @(posedge g_clk); #2;
            cfg_div        = vecs[v].div;
            cfg_parity_en  = vecs[v].par_en;
            cfg_parity_odd = vecs[v].par_odd;
            cfg_stop2      = vecs[v].stop2;
            p0 = pops;
            fifo_q.push_back(vecs[v].data);
            wait_pop($sformatf("vec%0d", v));
            capture(vecs[v].nbits * vecs[v].bitlen + 3, -1);
            check_frame($sformatf("vec%0d", v), 0, vecs[v].bits, vecs[v].nbits, vecs[v].bitlen);
            chk($sformatf("vec%0d_pops", v), pops - p0, 1);
        end

        // Back-to-back 0xA0, 0x0F with 2 stop bits at div 2: 22-cycle frames, 1-cycle gap.
        @(posedge g_clk); #2;
        cfg_div = 16'd2; cfg_parity_en = 1'b0; cfg_stop2 = 1'b1;
        p0 = pops;
        fifo_q.push_back(8'hA0);
        fifo_q.push_back(8'h0F);
        wait_pop("b2b");
        capture(50, -1);
        check_frame("b2b_f1", 0, 12'h740, 11, 2);
        check_frame("b2b_f2", 23, 12'h61E, 11, 2);
        chk("b2b_pops", pops - p0, 2);

        // Reset during DATA bit 3 of 0x00 at div 2, a second word still queued.
        @(posedge g_clk); #2;
        cfg_stop2 = 1'b0;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h00);
        wait_pop("rstmid");
        capture(8, -1);
        chk("rstmid_pre_tx", cap_tx[7], 1'b0);
        @(posedge g_clk); #2;
        g_reset = 1'b1;
        p0 = pops;
        @(negedge g_clk);
        chk("rstmid_busy_before", busy, 1'b1);
        @(negedge g_clk);
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_pop", in_pop, 1'b0);
        @(posedge g_clk); #2;
        g_reset = 1'b0;
        chk("rstmid_nopops", pops - p0, 0);
        wait_pop("rstmid_fresh");
        @(negedge g_clk);
        chk("rstmid_fresh_tx", tx, 1'b0);
        chk("rstmid_fresh_busy", busy, 1'b1);
        repeat (25) @(negedge g_clk);
        chk("rstmid_fresh_done", busy, 1'b0);

        // cfg_en dropped and div changed mid-frame: frame completes at div 8, no more pops.
        @(posedge g_clk); #2;
        cfg_div = 16'd8;
        p0 = pops;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h3C);
        wait_pop("en");
        capture(85, 20);
        check_frame("en", 0, 12'h278, 10, 8);
        repeat (10) @(negedge g_clk);
        chk("en_pops", pops - p0, 1);
        chk("en_clk_req", g_clk_req, 1'b0);
        chk("en_valid_held", in_valid, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule
